glyph_fetch_arbiter: RTL and testbench

GLYPH_FETCH_ARBITER -- requirements
Module: glyph_fetch_arbiter

---
 rtl/glyph_fetch_arbiter.sv | 166 ++++++++++++++++
 tb/tb_glyph_fetch_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_fetch_arbiter.sv
// Glyph ROM fetch arbiter: display and host share one ROM port, with a one-entry
// display skid buffer and starvation-forced host service. Optional stall counter: GLYPH_ARB_STATS_EN.
module glyph_fetch_arbiter #(
    parameter int unsigned HOST_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        disp_req,
    input  logic [5:0]  disp_char,
    input  logic [2:0]  disp_row,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    output logic        disp_ovf,
    input  logic        host_req,
    input  logic [5:0]  host_char,
    input  logic [2:0]  host_row,
    output logic        host_ack,
    output logic        host_valid,
    output logic [7:0]  host_data,
    output logic [8:0]  rom_addr,
    input  logic [7:0]  rom_q,
    output logic [15:0] stall_cnt
);

    localparam logic [3:0] STARVE_LIMIT = 4'(HOST_MAX);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_SKID = 2'd2,
        GNT_HOST = 2'd3
    } gnt_t;

    gnt_t       w_gnt;
    logic [8:0] w_gnt_addr;
    logic       w_host_gnt;
    logic       w_skid_load;
    logic       w_disp_drop;
    logic       w_host_wait;

    tag_t       r_tag1;
    tag_t       r_tag2;
    logic [8:0] r_rom_addr;
    logic       r_skid_vld;
    logic [8:0] r_skid_addr;
    logic [3:0] r_starve;
    logic       r_disp_valid;
    logic [7:0] r_disp_data;
    logic       r_disp_ovf;
    logic       r_host_valid;
    logic [7:0] r_host_data;

    // Skid first, then display unless the host has waited HOST_MAX cycles, then host.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!RST) begin
            if (r_skid_vld) begin
                w_gnt = GNT_SKID;
            end else if (disp_req && ((r_starve < STARVE_LIMIT) || !host_req)) begin
                w_gnt = GNT_DISP;
            end else if (host_req) begin
                w_gnt = GNT_HOST;
            end
        end
    end

    always_comb begin
        w_gnt_addr = r_rom_addr;
        case (w_gnt)
            GNT_SKID: w_gnt_addr = r_skid_addr;
            GNT_DISP: w_gnt_addr = {disp_char, disp_row};
            GNT_HOST: w_gnt_addr = {host_char, host_row};
            default:  w_gnt_addr = r_rom_addr;
        endcase
    end

    assign w_host_gnt  = (w_gnt == GNT_HOST);
    assign w_skid_load = w_host_gnt && disp_req;
    assign w_disp_drop = r_skid_vld && disp_req;
    assign w_host_wait = host_req && !w_host_gnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tag1       <= TAG_NONE;
            r_tag2       <= TAG_NONE;
            r_rom_addr   <= 9'd0;
            r_skid_vld   <= 1'b0;
            r_skid_addr  <= 9'd0;
            r_starve     <= 4'd0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= 8'd0;
            r_disp_ovf   <= 1'b0;
            r_host_valid <= 1'b0;
            r_host_data  <= 8'd0;
        end else begin
            if (w_gnt != GNT_NONE) begin
                r_rom_addr <= w_gnt_addr;
            end

            case (w_gnt)
                GNT_DISP, GNT_SKID: r_tag1 <= TAG_DISP;
                GNT_HOST:           r_tag1 <= TAG_HOST;
                default:            r_tag1 <= TAG_NONE;
            endcase
            r_tag2 <= r_tag1;

            // rom_q belongs to the access tagged two edges ago; the other data output holds.
            r_disp_valid <= (r_tag2 == TAG_DISP);
            r_host_valid <= (r_tag2 == TAG_HOST);
            if (r_tag2 == TAG_DISP) begin
                r_disp_data <= rom_q;
            end
            if (r_tag2 == TAG_HOST) begin
                r_host_data <= rom_q;
            end

            if (w_skid_load) begin
                r_skid_vld  <= 1'b1;
                r_skid_addr <= {disp_char, disp_row};
            end else if (w_gnt == GNT_SKID) begin
                r_skid_vld  <= 1'b0;
            end

            r_disp_ovf <= r_disp_ovf | w_disp_drop;

            if (w_host_wait) begin
                if (r_starve != 4'hF) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else begin
                r_starve <= 4'd0;
            end
        end
    end

    assign host_ack   = w_host_gnt;
    assign disp_valid = r_disp_valid;
    assign disp_data  = r_disp_data;
    assign disp_ovf   = r_disp_ovf;
    assign host_valid = r_host_valid;
    assign host_data  = r_host_data;
    assign rom_addr   = r_rom_addr;

`ifdef GLYPH_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= 16'd0;
        end else if (w_host_wait && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_glyph_fetch_arbiter.sv
// Bench for glyph_fetch_arbiter: directed scenarios plus random traffic checked
// every cycle against a queue-based latency model of the arbitration rules.
module tb_glyph_fetch_arbiter;

    localparam int HM     = 4;
    localparam int G_NONE = 0;
    localparam int G_DISP = 1;
    localparam int G_SKID = 2;
    localparam int G_HOST = 3;

    logic        CLK;
    logic        RST;
    logic        disp_req;
    logic [5:0]  disp_char;
    logic [2:0]  disp_row;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ovf;
    logic        host_req;
    logic [5:0]  host_char;
    logic [2:0]  host_row;
    logic        host_ack;
    logic        host_valid;
    logic [7:0]  host_data;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_q;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    glyph_fetch_arbiter #(.HOST_MAX(HM)) dut (
        .CLK(CLK), .RST(RST),
        .disp_req(disp_req), .disp_char(disp_char), .disp_row(disp_row),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ovf(disp_ovf),
        .host_req(host_req), .host_char(host_char), .host_row(host_row),
        .host_ack(host_ack), .host_valid(host_valid), .host_data(host_data),
        .rom_addr(rom_addr), .rom_q(rom_q), .stall_cnt(stall_cnt)
    );

    // ---------------- clock / reset / ROM ----------------
    initial CLK = 0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_fn(input logic [8:0] a);
        logic [15:0] t;
        t = 16'(a) * 16'd37 + 16'd11;
        return t[7:0] ^ {a[8:2], 1'b1};
    endfunction

    always @(posedge CLK) rom_q <= rom_fn(rom_addr);

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    logic [9:0] exp_q[$];
    int         due_q[$];
    int         cyc = 0;
    int         m_starve, m_stall;
    bit         m_skid_v, m_ovf;
    logic [8:0] m_skid_addr, m_rom_addr;
    bit         m_disp_valid, m_host_valid;
    logic [7:0] m_disp_data, m_host_data;

    function automatic int m_grant();
        if (m_skid_v) return G_SKID;
        if (disp_req && (m_starve < HM || !host_req)) return G_DISP;
        if (host_req) return G_HOST;
        return G_NONE;
    endfunction

    task automatic model_step();
        int         g;
        logic [9:0] e;
        logic [8:0] a;
        cyc++;
        if (RST) begin
            exp_q.delete(); due_q.delete();
            m_starve = 0; m_stall = 0; m_skid_v = 0; m_ovf = 0;
            m_skid_addr = 0; m_rom_addr = 0;
            m_disp_valid = 0; m_host_valid = 0; m_disp_data = 0; m_host_data = 0;
            return;
        end
        m_disp_valid = 0;
        m_host_valid = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            e = exp_q.pop_front();
            if (e[9]) begin m_host_valid = 1; m_host_data = rom_fn(e[8:0]); end
            else      begin m_disp_valid = 1; m_disp_data = rom_fn(e[8:0]); end
        end
        g = m_grant();
        a = (g == G_SKID) ? m_skid_addr :
            (g == G_DISP) ? {disp_char, disp_row} : {host_char, host_row};
        if (g != G_NONE) begin
            m_rom_addr = a;
            exp_q.push_back({(g == G_HOST), a});
            due_q.push_back(cyc + 2);
        end
        if (m_skid_v && disp_req) m_ovf = 1;
        if (g == G_SKID) m_skid_v = 0;
        if (g == G_HOST && disp_req) begin m_skid_v = 1; m_skid_addr = {disp_char, disp_row}; end
        if (host_req && g != G_HOST) begin
            m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            m_stall  = (m_stall < 65535) ? m_stall + 1 : 65535;
        end else begin
            m_starve = 0;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_stall();
`ifdef GLYPH_ARB_STATS_EN
        return 16'(m_stall);
`else
        return 16'd0;
`endif
    endfunction

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            check("disp_valid", 16'(disp_valid), 16'(m_disp_valid));
            check("disp_data",  16'(disp_data),  16'(m_disp_data));
            check("disp_ovf",   16'(disp_ovf),   16'(m_ovf));
            check("host_ack",   16'(host_ack),   16'(!RST && (m_grant() == G_HOST)));
            check("host_valid", 16'(host_valid), 16'(m_host_valid));
            check("host_data",  16'(host_data),  16'(m_host_data));
            check("rom_addr",   16'(rom_addr),   16'(m_rom_addr));
            check("stall_cnt",  stall_cnt,       exp_stall());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req = 0; disp_char = 0; disp_row = 0;
        host_req = 0; host_char = 0; host_row = 0;
    endtask

    task automatic do_reset();
        RST = 1;
        idle_inputs();
        tick();
        RST = 0;
    endtask

    task automatic set_disp(input int c, input int r);
        disp_req = 1; disp_char = 6'(c); disp_row = 3'(r);
    endtask

    task automatic set_host(input int c, input int r);
        host_req = 1; host_char = 6'(c); host_row = 3'(r);
    endtask

    // Display requests every cycle against a held host request until the forced grant.
    task automatic forced_run(input bit extra_disp);
        do_reset();
        set_host(33, 1);
        for (int i = 0; i < 5; i++) begin
            set_disp(10 + i, i);
            @(negedge CLK);
            check("forced_ack", 16'(host_ack), 16'(i == 4));
            tick();
        end
        host_req = 0;
        disp_req = 0;
        if (extra_disp) set_disp(50, 6);
        tick();
        disp_req = 0;
        tick();
        @(negedge CLK);
        check("forced_host_valid", 16'(host_valid), 16'd1);
        tick();
        @(negedge CLK);
        check("skid_disp_valid", 16'(disp_valid), 16'd1);
        check("skid_disp_data", 16'(disp_data), 16'(rom_fn({6'd14, 3'd4})));
        check("skid_ovf", 16'(disp_ovf), 16'(extra_disp));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ack_seen;
        RST = 1;
        idle_inputs();
        repeat (3) tick();
        RST = 0;
        chk_en = 1;

        // single display fetch, char 1 row 3
        do_reset();
        set_disp(1, 3);
        tick();
        disp_req = 0;
        @(negedge CLK);
        check("s1_rom_addr", 16'(rom_addr), 16'(9'o013));
        tick();
        @(negedge CLK);
        check("s1_no_early_valid", 16'(disp_valid), 16'd0);
        tick();
        @(negedge CLK);
        check("s1_disp_valid", 16'(disp_valid), 16'd1);
        check("s1_disp_data", 16'(disp_data), 16'(rom_fn(9'o013)));

        // simultaneous requests, display wins, host next
        do_reset();
        set_disp(5, 2);
        set_host(9, 7);
        @(negedge CLK);
        check("s2_ack_blocked", 16'(host_ack), 16'd0);
        tick();
        disp_req = 0;
        @(negedge CLK);
        check("s2_ack", 16'(host_ack), 16'd1);
        tick();
        host_req = 0;
        @(negedge CLK);
        check("s2_host_addr", 16'(rom_addr), 16'({6'd9, 3'd7}));
        tick();
        @(negedge CLK);
        check("s2_disp_valid", 16'(disp_valid), 16'd1);
        tick();
        @(negedge CLK);
        check("s2_host_valid", 16'(host_valid), 16'd1);
        check("s2_host_data", 16'(host_data), 16'(rom_fn({6'd9, 3'd7})));

        // forced host service, skid returns after 3 cycles, no overflow
        forced_run(0);

        // forced service then a request while skid is occupied: dropped, sticky overflow
        forced_run(1);
        repeat (5) tick();
        @(negedge CLK);
        check("s4_ovf_sticky", 16'(disp_ovf), 16'd1);
        do_reset();
        @(negedge CLK);
        check("s4_ovf_cleared", 16'(disp_ovf), 16'd0);

        // reset one cycle after a grant discards the access
        do_reset();
        set_disp(7, 5);
        set_host(20, 2);
        tick();
        disp_req = 0;
        RST = 1;
        @(negedge CLK);
        check("s5_ack_in_reset", 16'(host_ack), 16'd0);
        tick();
        RST = 0;
        host_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("s5_disp_valid", 16'(disp_valid), 16'd0);
            check("s5_host_valid", 16'(host_valid), 16'd0);
            check("s5_disp_data", 16'(disp_data), 16'd0);
            check("s5_rom_addr", 16'(rom_addr), 16'd0);
            tick();
        end

        // host blocked 4 + 3 cycles
        do_reset();
        set_host(40, 0);
        for (int i = 0; i < 5; i++) begin
            set_disp(i, i);
            tick();
        end
        idle_inputs();
        tick();
        set_host(41, 6);
        for (int i = 0; i < 3; i++) begin
            set_disp(20 + i, i);
            tick();
        end
        disp_req = 0;
        tick();
        host_req = 0;
        @(negedge CLK);
`ifdef GLYPH_ARB_STATS_EN
        check("s6_stall_cnt", stall_cnt, 16'd7);
`else
        check("s6_stall_cnt", stall_cnt, 16'd0);
`endif

        // random traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            @(negedge CLK);
            ack_seen = host_ack;
            tick();
            RST = ($urandom_range(0, 399) == 0);
            disp_req  = ($urandom_range(0, 99) < 45);
            disp_char = 6'($urandom_range(0, 63));
            disp_row  = 3'($urandom_range(0, 7));
            if (!host_req || ack_seen) begin
                host_req  = ($urandom_range(0, 99) < 55);
                host_char = 6'($urandom_range(0, 63));
                host_row  = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 99) < 4) begin
                host_req = 0;
            end
        end
        RST = 0;
        idle_inputs();
        repeat (4) tick();
        @(negedge CLK);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
